// File: rtl/pulse_width_decoder.sv
// ----------------------------------------------------------------------------
// pulse_width_decoder
//
// Receive-side counterpart of the bit-sync pulse stretcher. Measures the
// width of each stretched high pulse on din in clk32 cycles. A pulse of
// acceptable width becomes one single-cycle strobe on dout, and the
// measured width is latched on width. A pulse that is too short or too
// long instead raises a single-cycle err.
//
// Parameters:
//   MIN_W  minimum accepted pulse width in clk32 cycles (>= 1)
//   MAX_W  maximum accepted pulse width in clk32 cycles (>= MIN_W)
//   CW     width counter bits; needs MAX_W + 2 < 2**CW
//
// Ports:
//   clk32  in   system clock, 32 MHz
//   rst    in   asynchronous reset, active-low
//   din    in   stretched pulse input, synchronous to clk32
//   dout   out  one-cycle strobe per pulse with width in [MIN_W, MAX_W]
//   width  out  width of the last accepted pulse, held until the next one
//   err    out  one-cycle flag per pulse that is too short or too long
//
// Optional feature (macro PULSE_DEC_GLITCH_EN):
//   When defined, a single low cycle inside a pulse is bridged through a
//   GAP state, so two pulses separated by exactly one low cycle merge into
//   one. End-of-pulse events then come out one clock later.
// ----------------------------------------------------------------------------
module pulse_width_decoder #(
    parameter int unsigned MIN_W = 2,
    parameter int unsigned MAX_W = 8,
    parameter int unsigned CW    = 4
) (
    input  logic          clk32,
    input  logic          rst,
    input  logic          din,
    output logic          dout,
    output logic [CW-1:0] width,
    output logic          err
);

    localparam logic [CW-1:0] MinW = CW'(MIN_W);
    localparam logic [CW-1:0] MaxW = CW'(MAX_W);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLong,
        StGap
    } state_e;

    state_e        state_q, state_d;
    logic          d_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dout_q, dout_d;
    logic          err_q, err_d;
    logic [CW-1:0] width_q, width_d;

    // Set when the current cycle closes a pulse and its width must be judged.
    logic          end_of_pulse;

`ifdef PULSE_DEC_GLITCH_EN
    // Width once the bridged low cycle and the current high cycle are counted.
    logic [CW-1:0] gap_sum;
`endif

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk32 or negedge rst) begin
        if (!rst) begin
            d_q     <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            err_q   <= 1'b0;
            width_q <= '0;
        end else begin
            d_q     <= din;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            width_q <= width_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic; every decision looks at the registered d_q only.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dout_d       = 1'b0;
        err_d        = 1'b0;
        width_d      = width_q;
        end_of_pulse = 1'b0;
`ifdef PULSE_DEC_GLITCH_EN
        gap_sum      = cnt_q + CW'(2);
`endif

        case (state_q)
            StIdle: begin
                if (d_q) begin
                    state_d = StHigh;
                    cnt_d   = CW'(1);
                end
            end

            StHigh: begin
                if (d_q) begin
                    if (cnt_q == MaxW) begin
                        // Too long: flag once now, then ride out the pulse.
                        state_d = StLong;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
`ifdef PULSE_DEC_GLITCH_EN
                    // Hold the count; one low cycle may still be a glitch.
                    state_d = StGap;
`else
                    end_of_pulse = 1'b1;
`endif
                end
            end

            StLong: begin
                // Already reported; no further err and never a dout.
                if (!d_q) begin
                    state_d = StIdle;
                end
            end

`ifdef PULSE_DEC_GLITCH_EN
            StGap: begin
                if (d_q) begin
                    if (gap_sum > MaxW) begin
                        state_d = StLong;
                        err_d   = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = StHigh;
                        cnt_d   = gap_sum;
                    end
                end else begin
                    // Second low cycle: the pulse really ended.
                    end_of_pulse = 1'b1;
                end
            end
`endif

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Judge the width of a finished pulse. A too-short pulse leaves the
        // previously accepted width on the output untouched.
        if (end_of_pulse) begin
            if (cnt_q >= MinW && cnt_q <= MaxW) begin
                dout_d  = 1'b1;
                width_d = cnt_q;
            end else begin
                err_d = 1'b1;
            end
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    assign dout  = dout_q;
    assign err   = err_q;
    assign width = width_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// ----------------------------------------------------------------------------
// tb_pulse_width_decoder
//
// Directed bench for pulse_width_decoder. din/rst are driven on the falling
// edge, so each step's value is sampled into d_q by the next rising edge.
// Outputs are checked on every falling edge against a scoreboard of expected
// dout/err events, each tagged with the rising-edge index at which it must
// appear, and against the expected held width.
// ----------------------------------------------------------------------------
module tb_pulse_width_decoder;

    localparam int unsigned MIN_W = 2;
    localparam int unsigned MAX_W = 8;
    localparam int unsigned CW    = 4;

`ifdef PULSE_DEC_GLITCH_EN
    localparam int GL = 1;  // extra end-of-pulse latency of the GAP state
`else
    localparam int GL = 0;
`endif

    logic          clk32 = 1'b0;
    logic          rst;
    logic          din;
    logic          dout;
    logic          err;
    logic [CW-1:0] width;

    always #5 clk32 = ~clk32;

    pulse_width_decoder #(
        .MIN_W (MIN_W),
        .MAX_W (MAX_W),
        .CW    (CW)
    ) dut (
        .clk32 (clk32),
        .rst   (rst),
        .din   (din),
        .dout  (dout),
        .width (width),
        .err   (err)
    );

    typedef struct {
        int            cyc;
        logic          is_err;
        logic [CW-1:0] w;
    } ev_t;

    ev_t           sb[$];
    int            cyc         = 0;
    int            vectors     = 0;
    int            miscompares = 0;
    logic [CW-1:0] exp_width   = '0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Compare outputs right after rising edge number cyc.
    task automatic check();
        ev_t  ev;
        logic e_dout;
        logic e_err;
        e_dout = 1'b0;
        e_err  = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            ev = sb.pop_front();
            if (ev.is_err) begin
                e_err = 1'b1;
            end else begin
                e_dout    = 1'b1;
                exp_width = ev.w;
            end
        end
        cmp("dout", 32'(dout), 32'(e_dout));
        cmp("err", 32'(err), 32'(e_err));
        cmp("width", 32'(width), 32'(exp_width));
    endtask

    // One clock: check the previous edge's results, then drive the next inputs.
    task automatic step(input logic d, input logic r);
        @(negedge clk32);
        cyc++;
        check();
        din = d;
        rst = r;
        if (!r) begin
            exp_width = '0;
            #1;
            cmp("rst_dout", 32'(dout), 32'd0);
            cmp("rst_err", 32'(err), 32'd0);
            cmp("rst_width", 32'(width), 32'd0);
        end
    endtask

    // Expected event for a pulse whose first high sample is at rising edge s.
    task automatic expect_pulse(input int s, input int w);
        ev_t ev;
        if (w > int'(MAX_W)) begin
            ev = '{s + int'(MAX_W) + 1, 1'b1, CW'(0)};
        end else if (w < int'(MIN_W)) begin
            ev = '{s + w + 1 + GL, 1'b1, CW'(0)};
        end else begin
            ev = '{s + w + 1 + GL, 1'b0, CW'(w)};
        end
        sb.push_back(ev);
    endtask

    task automatic pulse(input int hi, input int lo);
        expect_pulse(cyc + 2, hi);
        repeat (hi) step(1'b1, 1'b1);
        repeat (lo) step(1'b0, 1'b1);
    endtask

    initial begin
        int s;
        rst = 1'b0;
        din = 1'b0;

        // Reset held with din toggling, then release with din low.
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);

        // Nominal 4-cycle pulse, then a too-short one that keeps width=4.
        pulse(4, 4);
        pulse(1, 4);

        // Too long: one err only, nothing at the falling edge.
        pulse(12, 4);

        // Boundaries: exactly MIN_W, exactly MAX_W, MAX_W+1.
        pulse(2, 4);
        pulse(8, 4);
        pulse(9, 4);

        // 3 high, 1 low, 5 high.
        s = cyc + 2;
`ifdef PULSE_DEC_GLITCH_EN
        expect_pulse(s, 9);
`else
        expect_pulse(s, 3);
        expect_pulse(s + 4, 5);
`endif
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (5) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        // 2 high, 1 low, 2 high.
        s = cyc + 2;
`ifdef PULSE_DEC_GLITCH_EN
        expect_pulse(s, 5);
`else
        expect_pulse(s, 2);
        expect_pulse(s + 3, 2);
`endif
        repeat (2) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (2) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        // Reset during the 3rd cycle of a 6-cycle pulse; 3 highs remain.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        expect_pulse(cyc + 2, 3);
        repeat (3) step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        // Same reset, but only one high cycle remains after release.
        repeat (4) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        expect_pulse(cyc + 2, 1);
        step(1'b1, 1'b1);
        repeat (5) step(1'b0, 1'b1);

        cmp("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pulse_width_decoder.md
Name: pulse_width_decoder

Overview:
- Receive-side counterpart of the pulse stretcher used in bit-sync paths.
- Takes stretched high pulses, such as the 4-cycle pulses from a monostable, and measures each pulse width in clk32 cycles.
- For each pulse it either regenerates one single-cycle strobe or flags a width error.
- Sits between the sync pulse generator and downstream symbol-timing logic in the demodulator.

Parameters:
- MIN_W, 2: minimum accepted pulse width in clk32 cycles, >=1.
- MAX_W, 8: maximum accepted pulse width in clk32 cycles, MIN_W<=MAX_W.
- CW, 4: width counter bits; requires MAX_W+2 < 2^CW.

Ports:
- clk32, input, 1: system clock, 32 MHz.
- rst, input, 1: asynchronous reset, active-low.
- din, input, 1: stretched pulse input, synchronous to clk32.
- dout, output, 1: single-cycle strobe for each pulse whose width is in [MIN_W,MAX_W].
- width, output, CW: measured width of the last accepted pulse; held until the next accepted pulse.
- err, output, 1: single-cycle flag for a pulse that is too short or too long.

Behaviour:
- Reset (rst=0, async): d_q=0, cnt=0, state=IDLE, dout=0, err=0, width=0.
- d_q <= din every clock. All decisions use d_q only.
- dout and err are registered and high for exactly one cycle per event. They are never asserted together.
- IDLE:
  - d_q=1 -> HIGH, cnt=1.
  - Otherwise stay in IDLE.
- HIGH, d_q=1:
  - If cnt==MAX_W -> LONG, err=1.
  - Else cnt=cnt+1.
- HIGH, d_q=0 (end of pulse):
  - MIN_W<=cnt<=MAX_W -> dout=1, width=cnt.
  - cnt<MIN_W -> err=1, width unchanged.
  - In both cases -> IDLE, cnt=0.
- LONG:
  - Wait while d_q=1. No further err, no dout.
  - d_q=0 -> IDLE.
- Latency: dout/err for an end-of-pulse event asserts in the 2nd clock after the first clk32 edge that samples din low.
- Latency: the too-long err asserts 2 clocks after the edge that samples the (MAX_W+1)th high cycle.
- A 1-cycle low gap between pulses is resolved as two separate pulses. IDLE accepts d_q=1 on the cycle immediately after the end-of-pulse evaluation.
- The counter never wraps: maximum stored value is MAX_W.
- Reset mid-pulse clears everything. After release, if din is still high, the remainder is measured as a new pulse.
- Single-cycle pulse with MIN_W=1: accepted, width=1.

Optional Feature:
- Macro PULSE_DEC_GLITCH_EN.
- Defined:
  - A single low cycle inside a pulse is bridged.
  - HIGH with d_q=0 -> GAP state, cnt held.
  - GAP with d_q=1 -> HIGH, cnt=cnt+2, covering the gap and the current cycle. If the result exceeds MAX_W -> LONG, err=1.
  - GAP with d_q=0 -> end-of-pulse evaluation of cnt as in HIGH.
  - End-of-pulse latency grows by 1 clock.
  - Two pulses separated by exactly one low cycle merge into one pulse.
- Undefined: no GAP state; behaviour exactly as above.

Test Plan (defaults MIN_W=2, MAX_W=8, macro undefined unless stated):
1. Hold rst=0 for 3 cycles with din toggling -> dout=0, err=0, width=0 throughout; release -> still 0 with din=0.
2. din high 4 cycles -> exactly one dout pulse, 2 clocks after din sampled low; width=4; err never high.
3. din high 1 cycle -> err high for one cycle; no dout; width keeps its previous value (4).
4. din high 12 cycles -> single err 2 clocks after the 9th high sample; no dout and no second err at the falling edge; width unchanged.
5. din 3 high, 1 low, 5 high -> two dout strobes, width=3 then width=5.
   - Same stimulus with PULSE_DEC_GLITCH_EN -> one dout, width=9 exceeds MAX_W so err instead.
   - Variant 2 high, 1 low, 2 high -> one dout, width=5.
6. rst pulsed low during the 3rd cycle of a 6-cycle pulse -> outputs clear immediately; after release, the remaining high cycles produce dout with width equal to the cycles remaining after release (>=2), or err if fewer than 2.
